// File: rtl/key_search_pkg.sv
// Shared definitions for the RC4 key-search scheduler: FSM state codes and S-RAM owner codes.
package key_search_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE      = 4'd0;
    localparam state_t S_LOAD_KEY  = 4'd1;
    localparam state_t S_INIT      = 4'd2;
    localparam state_t S_W_INIT    = 4'd3;
    localparam state_t S_SHUF      = 4'd4;
    localparam state_t S_W_SHUF    = 4'd5;
    localparam state_t S_DEC       = 4'd6;
    localparam state_t S_W_DEC     = 4'd7;
    localparam state_t S_CHK       = 4'd8;
    localparam state_t S_W_CHK     = 4'd9;
    localparam state_t S_NEXT_KEY  = 4'd10;
    localparam state_t S_FOUND     = 4'd11;
    localparam state_t S_EXHAUSTED = 4'd12;
    localparam state_t S_ERROR     = 4'd13;

    localparam logic [1:0] MEM_INIT = 2'd0;
    localparam logic [1:0] MEM_SHUF = 2'd1;
    localparam logic [1:0] MEM_DEC  = 2'd2;
    localparam logic [1:0] MEM_NONE = 2'd3;

    function automatic logic is_wait(input state_t s);
        return (s == S_W_INIT) || (s == S_W_SHUF) || (s == S_W_DEC) || (s == S_W_CHK);
    endfunction

    // States in which start is honoured and the search is not running.
    function automatic logic is_parked(input state_t s);
        return (s == S_IDLE) || (s == S_FOUND) || (s == S_EXHAUSTED) || (s == S_ERROR);
    endfunction

endpackage

// File: rtl/flopr_en.sv
// Resettable register with synchronous clear and enable; clear wins over enable.
module flopr_en #(
    parameter int              W       = 8,
    parameter logic [W-1:0]    RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= RST_VAL;
        else if (clr)
            q <= RST_VAL;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/stage_watchdog.sv
// Per-stage down-counter: reloaded by each stage launch, expires after TIMEOUT_CYCLES-1 wait cycles
// so the FSM lands in ERROR exactly TIMEOUT_CYCLES cycles after the launch pulse.
module stage_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic count,
    output logic expired
);

    localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (load)
            r_cnt <= LOAD_VAL;
        else if (count && (r_cnt != '0))
            r_cnt <= r_cnt - CW'(1);
    end

    assign expired = count && (r_cnt == CW'(1));

endmodule

// File: rtl/key_search_ctrl.sv
// RC4 key-search scheduler: sequences init/shuffle/decrypt/check per key and owns the S-RAM select.
// Optional per-stage watchdog enabled by defining KEY_SEARCH_TIMEOUT_EN.
module key_search_ctrl
    import key_search_pkg::*;
#(
    parameter int                    KEY_WIDTH      = 24,
    parameter logic [KEY_WIDTH-1:0]  KEY_START      = 24'h000000,
    parameter logic [KEY_WIDTH-1:0]  KEY_MAX        = 24'h3FFFFF,
    parameter int                    TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [KEY_WIDTH-1:0] secret_key,
    output logic                 init_start,
    input  logic                 init_finished,
    output logic                 shuffle_start,
    input  logic                 shuffle_finished,
    output logic                 decrypt_start,
    input  logic                 decrypt_finished,
    output logic                 check_start,
    input  logic                 check_finished,
    input  logic                 check_pass,
    output logic [1:0]           mem_sel,
    output logic                 busy,
    output logic                 found,
    output logic                 exhausted,
    output logic                 err
);

    // The watchdog reloads with TIMEOUT_CYCLES-1 and expires on reaching 1, so it needs at least 2.
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("key_search_ctrl: TIMEOUT_CYCLES must be at least 2");
    end

    state_t r_state;
    state_t w_next;
    logic   w_launch;
    logic   w_key_clr;
    logic   w_key_en;
    logic   w_at_max;
    logic   w_expired;

    assign w_at_max  = (secret_key == KEY_MAX);
    assign w_key_clr = (r_state == S_LOAD_KEY);
    assign w_key_en  = (r_state == S_NEXT_KEY);
    assign w_launch  = (r_state == S_INIT) || (r_state == S_SHUF) ||
                       (r_state == S_DEC)  || (r_state == S_CHK);

    flopr_en #(
        .W       (KEY_WIDTH),
        .RST_VAL (KEY_START)
    ) u_key (
        .clk   (clk),
        .reset (reset),
        .en    (w_key_en),
        .clr   (w_key_clr),
        .d     (secret_key + KEY_WIDTH'(1)),
        .q     (secret_key)
    );

`ifdef KEY_SEARCH_TIMEOUT_EN
    stage_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .load    (w_launch),
        .count   (is_wait(r_state)),
        .expired (w_expired)
    );
    assign err = (r_state == S_ERROR);
`else
    assign w_expired = 1'b0;
    assign err       = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_FOUND, S_EXHAUSTED, S_ERROR: if (start) w_next = S_LOAD_KEY;
            S_LOAD_KEY: w_next = S_INIT;
            S_INIT:     w_next = S_W_INIT;
            S_W_INIT:   if (init_finished) w_next = S_SHUF;
            S_SHUF:     w_next = S_W_SHUF;
            S_W_SHUF:   if (shuffle_finished) w_next = S_DEC;
            S_DEC:      w_next = S_W_DEC;
            S_W_DEC:    if (decrypt_finished) w_next = S_CHK;
            S_CHK:      w_next = S_W_CHK;
            // An accept outranks a reject arriving in the same cycle.
            S_W_CHK: begin
                if (check_pass)
                    w_next = S_FOUND;
                else if (check_finished)
                    w_next = w_at_max ? S_EXHAUSTED : S_NEXT_KEY;
            end
            S_NEXT_KEY: w_next = S_INIT;
            default:    w_next = S_IDLE;
        endcase
        // A stage that completes on the expiry cycle still advances normally.
        if (w_expired && (w_next == r_state))
            w_next = S_ERROR;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        mem_sel = MEM_NONE;
        case (r_state)
            S_INIT, S_W_INIT: mem_sel = MEM_INIT;
            S_SHUF, S_W_SHUF: mem_sel = MEM_SHUF;
            S_DEC,  S_W_DEC:  mem_sel = MEM_DEC;
            default:          mem_sel = MEM_NONE;
        endcase
    end

    assign init_start    = (r_state == S_INIT);
    assign shuffle_start = (r_state == S_SHUF);
    assign decrypt_start = (r_state == S_DEC);
    assign check_start   = (r_state == S_CHK);
    assign busy          = !is_parked(r_state) && (r_state != S_LOAD_KEY);
    assign found         = (r_state == S_FOUND);
    assign exhausted     = (r_state == S_EXHAUSTED);

endmodule

// File: tb/tb_key_search_ctrl.sv
// Randomised bench for key_search_ctrl: a scripted stage model predicts every output each cycle.
module tb_key_search_ctrl;

    localparam int          KW = 24;
    localparam logic [23:0] KS = 24'h000000;
    localparam logic [23:0] KM = 24'h000007;
    localparam int          TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [KW-1:0] secret_key;
    logic          init_start, shuffle_start, decrypt_start, check_start;
    logic          init_finished, shuffle_finished, decrypt_finished;
    logic          check_finished, check_pass;
    logic [1:0]    mem_sel;
    logic          busy, found, exhausted, err;

    key_search_ctrl #(
        .KEY_WIDTH      (KW),
        .KEY_START      (KS),
        .KEY_MAX        (KM),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .secret_key       (secret_key),
        .init_start       (init_start),
        .init_finished    (init_finished),
        .shuffle_start    (shuffle_start),
        .shuffle_finished (shuffle_finished),
        .decrypt_start    (decrypt_start),
        .decrypt_finished (decrypt_finished),
        .check_start      (check_start),
        .check_finished   (check_finished),
        .check_pass       (check_pass),
        .mem_sel          (mem_sel),
        .busy             (busy),
        .found            (found),
        .exhausted        (exhausted),
        .err              (err)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Expected outputs for the current cycle, written by the stimulus script.
    logic [23:0] e_key;
    logic [1:0]  e_mem;
    logic [3:0]  e_pulse;
    bit          e_busy, e_found, e_exh, e_err;
    bit          chk_en = 1'b0;

    bit          lit_req = 1'b0;
    string       lit_nm;
    int          lit_act, lit_exp;

    int total = 0;
    int bad   = 0;
    int n_chk = 0;
    int found_cyc = 0;
    bit found_q = 1'b0;
    int t0, n0;

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, exp_v);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (check_start === 1'b1) n_chk++;
            if (found === 1'b1 && !found_q) found_cyc = cyc_cnt;
            found_q = (found === 1'b1);
            if (chk_en) begin
                chk("secret_key", int'(secret_key), int'(e_key));
                chk("mem_sel",    int'(mem_sel),    int'(e_mem));
                chk("start_pulses", int'({init_start, shuffle_start, decrypt_start, check_start}),
                    int'(e_pulse));
                chk("busy",      int'(busy),      int'(e_busy));
                chk("found",     int'(found),     int'(e_found));
                chk("exhausted", int'(exhausted), int'(e_exh));
                chk("err",       int'(err),       int'(e_err));
            end
            if (lit_req) chk(lit_nm, lit_act, lit_exp);
        end
    end

    task automatic adv();
        @(posedge clk);
        #1;
        lit_req = 1'b0;
    endtask

    task automatic lit(input string nm, input int act, input int exp_v);
        lit_nm  = nm;
        lit_act = act;
        lit_exp = exp_v;
        lit_req = 1'b1;
    endtask

    // Randomise every completion input except the one the script owns (tgt: 1 init .. 4 check).
    task automatic noise(input int tgt, input bit allow_start);
        init_finished    = (tgt != 1) && ($urandom_range(0, 3) == 0);
        shuffle_finished = (tgt != 2) && ($urandom_range(0, 3) == 0);
        decrypt_finished = (tgt != 3) && ($urandom_range(0, 3) == 0);
        check_finished   = (tgt != 4) && ($urandom_range(0, 3) == 0);
        check_pass       = (tgt != 4) && ($urandom_range(0, 3) == 0);
        start            = allow_start && ($urandom_range(0, 3) == 0);
    endtask

    task automatic exp_set(input logic [1:0] mem, input logic [3:0] pulse, input bit bsy);
        e_mem   = mem;
        e_pulse = pulse;
        e_busy  = bsy;
        e_found = 1'b0;
        e_exh   = 1'b0;
        e_err   = 1'b0;
    endtask

    // One search from a parked state. lat=0 picks random stage times; abort_key resets the DUT in
    // W_DEC of that key; hang_key never finishes decrypt for that key.
    task automatic run_search(input int pass_key, input bit both, input int lat,
                              input int abort_key, input int hang_key);
        int  l;
        bit  done;
        bit  pass;
        noise(0, 1'b0);
        start = 1'b1;
        t0 = cyc_cnt;
        n0 = n_chk;
        adv();
        noise(0, 1'b1);
        exp_set(2'd3, 4'b0000, 1'b0);
        adv();
        e_key = KS;
        done = 1'b0;
        while (!done) begin
            for (int s = 0; s < 3; s++) begin
                l = (lat != 0) ? lat : $urandom_range(1, 6);
                noise(0, 1'b1);
                exp_set(2'(s), 4'b1000 >> s, 1'b1);
                adv();
                if (s == 2 && int'(e_key) == abort_key) begin
                    noise(3, 1'b1);
                    exp_set(2'd3, 4'b0000, 1'b0);
                    e_key = KS;
                    #1 reset = 1'b1;
                    adv();
                    reset = 1'b0;
                    noise(0, 1'b0);
                    adv();
                    return;
                end
                if (s == 2 && int'(e_key) == hang_key) begin
                    for (int k = 1; k < TO; k++) begin
                        noise(3, 1'b1);
                        exp_set(2'd2, 4'b0000, 1'b1);
                        adv();
                    end
                    exp_set(2'd3, 4'b0000, 1'b0);
                    e_err = 1'b1;
                    done = 1'b1;
                    break;
                end
                for (int k = 1; k <= l; k++) begin
                    noise(s + 1, 1'b1);
                    if (s == 0) init_finished    = (k == l);
                    if (s == 1) shuffle_finished = (k == l);
                    if (s == 2) decrypt_finished = (k == l);
                    exp_set(2'(s), 4'b0000, 1'b1);
                    adv();
                end
            end
            if (done) break;
            l = (lat != 0) ? lat : $urandom_range(1, 6);
            pass = (int'(e_key) == pass_key);
            noise(0, 1'b1);
            exp_set(2'd3, 4'b0001, 1'b1);
            adv();
            for (int k = 1; k <= l; k++) begin
                noise(4, 1'b1);
                check_pass     = (k == l) && pass;
                check_finished = (k == l) && (!pass || both);
                exp_set(2'd3, 4'b0000, 1'b1);
                adv();
            end
            if (pass) begin
                exp_set(2'd3, 4'b0000, 1'b0);
                e_found = 1'b1;
                done = 1'b1;
            end else if (e_key == KM) begin
                exp_set(2'd3, 4'b0000, 1'b0);
                e_exh = 1'b1;
                done = 1'b1;
            end else begin
                noise(0, 1'b1);
                exp_set(2'd3, 4'b0000, 1'b1);
                adv();
                e_key = e_key + 24'd1;
            end
        end
        repeat (3) begin
            noise(0, 1'b0);
            adv();
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        init_finished = 1'b0;
        shuffle_finished = 1'b0;
        decrypt_finished = 1'b0;
        check_finished = 1'b0;
        check_pass = 1'b0;
        e_key = KS;
        exp_set(2'd3, 4'b0000, 1'b0);
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        adv();
        reset = 1'b0;
        adv();

        // Fixed 3-cycle stages, pass at key 5: 5 keys x 17 cycles + 2 + 16 to FOUND.
        run_search(5, 1'b0, 3, -1, -1);
        lit("found_latency", found_cyc - t0, 103);
        adv();
        lit("check_launches_found", n_chk - n0, 6);
        adv();
        lit("found_key", int'(secret_key), 5);
        adv();

        run_search(2, 1'b1, 0, -1, -1);
        lit("pass_and_reject_key", int'(secret_key), 2);
        adv();

        run_search(-1, 1'b0, 0, -1, -1);
        lit("check_launches_exhaust", n_chk - n0, 8);
        adv();
        lit("exhausted_key", int'(secret_key), 7);
        adv();

        run_search(-1, 1'b0, 0, 2, -1);

`ifdef KEY_SEARCH_TIMEOUT_EN
        run_search(-1, 1'b0, 0, -1, 1);
        lit("timeout_key", int'(secret_key), 1);
        adv();
`endif

        repeat (6) run_search($urandom_range(0, 9), 1'($urandom_range(0, 1)), 0, -1, -1);

        adv();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
